// File: rtl/fisr_pkg.sv
// Shared constants and float payload type for the fast inverse square root datapath.
package fisr_pkg;

    localparam int unsigned FP_BIAS = 127;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned EXP_W   = 8;

    localparam logic [31:0] THREE_HALVES = 32'h3FC00000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/lzc_n.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module lzc_n #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] count
);

    logic found;

    always_comb begin
        count = '0;
        found = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (!found) begin
                if (din[i]) begin
                    found = 1'b1;
                end else begin
                    count = count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/three_halves_sub.sv
// Newton-Raphson 1.5 - h stage: 3-deep ce-gated pipeline with valid and
// initial-guess side-band, truncating arithmetic throughout.
module three_halves_sub
    import fisr_pkg::*;
#(
    parameter int unsigned GUARD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] Number,
    input  logic [31:0] Init_in,
    input  logic        Valid_in,
    output logic [31:0] Result,
    output logic [31:0] Init_data,
    output logic        Valid
);

    localparam int unsigned W   = 24 + GUARD;
    localparam int unsigned LZW = $clog2(W + 1);

    // 1.5 as a W-bit fixed-point value whose LSB sits GUARD bits below the float ulp of 1.0
    localparam logic [W-1:0] A_ALIGNED = W'({1'b1, THREE_HALVES[MANT_W-1:0]}) << GUARD;

    // S1: alignment and subtraction
    fp32_t            num_c;
    logic [EXP_W-1:0] shift_c;
    logic [W-1:0]     sig_c;
    logic [W-1:0]     b_c;
    logic             clamp_c;
    logic [W-1:0]     diff_c;

    always_comb begin
        num_c   = Number;
        shift_c = EXP_W'(FP_BIAS) - num_c.exp;
        sig_c   = W'({1'b1, num_c.mant}) << GUARD;
        b_c     = '0;
        if (num_c.exp != '0 && 32'(shift_c) < W) begin
            b_c = sig_c >> shift_c;
        end
        // Anything at or above 2.0 also lands here, so the result never goes negative
        clamp_c = (num_c.exp > EXP_W'(FP_BIAS)) || (b_c > A_ALIGNED);
        diff_c  = clamp_c ? '0 : A_ALIGNED - b_c;
    end

    logic [W-1:0] s1_diff;
    logic         s1_clamp;
    logic [31:0]  s1_init;
    logic         s1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_diff  <= '0;
            s1_clamp <= 1'b0;
            s1_init  <= '0;
            s1_valid <= 1'b0;
        end else if (ce) begin
            s1_diff  <= diff_c;
            s1_clamp <= clamp_c;
            s1_init  <= Init_in;
            s1_valid <= Valid_in;
        end
    end

    // S2: leading-zero count
    logic [LZW-1:0] lz_c;
    logic           zero_c;

    lzc_n #(
        .WIDTH (W),
        .CNT_W (LZW)
    ) u_lzc (
        .din   (s1_diff),
        .count (lz_c)
    );

    assign zero_c = s1_clamp || (s1_diff == '0);

    logic [W-1:0]   s2_diff;
    logic [LZW-1:0] s2_lz;
    logic           s2_zero;
    logic [31:0]    s2_init;
    logic           s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_diff  <= '0;
            s2_lz    <= '0;
            s2_zero  <= 1'b0;
            s2_init  <= '0;
            s2_valid <= 1'b0;
        end else if (ce) begin
            s2_diff  <= s1_diff;
            s2_lz    <= lz_c;
            s2_zero  <= zero_c;
            s2_init  <= s1_init;
            s2_valid <= s1_valid;
        end
    end

    // S3: normalise and pack; the leading one drops out as the hidden bit
    logic [W-1:0] norm_c;
    fp32_t        res_c;

    always_comb begin
        norm_c     = s2_diff << s2_lz;
        res_c.sign = 1'b0;
        res_c.exp  = EXP_W'(FP_BIAS) - EXP_W'(s2_lz);
        res_c.mant = norm_c[MANT_W-1+GUARD:GUARD];
        if (s2_zero) begin
            res_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Result    <= '0;
            Init_data <= '0;
            Valid     <= 1'b0;
        end else if (ce) begin
            Result    <= res_c;
            Init_data <= s2_init;
            Valid     <= s2_valid;
        end
    end

    logic unused_c;
    assign unused_c = ^{num_c.sign, norm_c[W-1], norm_c[GUARD-1:0]};

endmodule

// File: tb/tb_three_halves_sub.sv
// Directed-table and streaming checks for three_halves_sub against a cycle model.
module tb_three_halves_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] Number;
    logic [31:0] Init_in;
    logic        Valid_in;
    logic [31:0] Result;
    logic [31:0] Init_data;
    logic        Valid;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    three_halves_sub dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .Number    (Number),
        .Init_in   (Init_in),
        .Valid_in  (Valid_in),
        .Result    (Result),
        .Init_data (Init_data),
        .Valid     (Valid)
    );

    typedef struct {
        logic [31:0] num;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    // Expected pipeline contents, advanced in step with the DUT
    logic        mv[3];
    logic [31:0] mr[3];
    logic [31:0] mi[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Truncating reference for 1.5 - x on a 2^-25 fixed-point grid
    function automatic logic [31:0] ref_sub(input logic [31:0] n);
        int     e;
        int     p;
        longint m;
        longint xf;
        longint d;
        longint mant;
        e = int'(n[30:23]);
        if (e == 0) return 32'h3FC00000;
        if (e > 127) return 32'h0;
        m = longint'({1'b1, n[22:0]});
        if (e >= 125) xf = m << (e - 125);
        else if (125 - e >= 40) xf = 0;
        else xf = m >> (125 - e);
        if (xf >= 64'h3000000) return 32'h0;
        d = 64'h3000000 - xf;
        p = 0;
        for (int i = 0; i < 26; i++) if (d[i]) p = i;
        if (p >= 23) mant = d >> (p - 23);
        else mant = d << (23 - p);
        return {1'b0, 8'(127 + p - 25), 23'(mant)};
    endfunction

    task automatic step(input logic r, input logic c, input logic v,
                        input logic [31:0] n, input logic [31:0] init, input logic [31:0] exp);
        logic [31:0] pr;
        logic [31:0] pi;
        logic        pv;
        rst      = r;
        ce       = c;
        Valid_in = v;
        Number   = n;
        Init_in  = init;
        pr = Result;
        pi = Init_data;
        pv = Valid;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                mv[k] = 1'b0;
                mr[k] = '0;
                mi[k] = '0;
            end
        end else if (c) begin
            for (int k = 2; k > 0; k--) begin
                mv[k] = mv[k-1];
                mr[k] = mr[k-1];
                mi[k] = mi[k-1];
            end
            mv[0] = v;
            mr[0] = exp;
            mi[0] = init;
        end
        #1;
        chk("valid", 32'(Valid), 32'(mv[2]));
        if (mv[2]) begin
            chk("result", Result, mr[2]);
            chk("init_data", Init_data, mi[2]);
        end
        if (!r && !c) begin
            chk("hold_result", Result, pr);
            chk("hold_init", Init_data, pi);
            chk("hold_valid", 32'(Valid), 32'(pv));
        end
    endtask

    task automatic idle(input logic c);
        step(1'b0, c, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        int          vin;
        int          vout;
        logic        c;
        logic        v;
        logic [31:0] n;
        logic [7:0]  e;
        logic [31:0] m;
        logic [31:0] ops[4];

        vecs[0]  = '{32'h3F000000, 32'h3F800000};
        vecs[1]  = '{32'h3F800000, 32'h3F000000};
        vecs[2]  = '{32'h3FA00000, 32'h3E800000};
        vecs[3]  = '{32'h3FC00000, 32'h00000000};
        vecs[4]  = '{32'h3FC00001, 32'h00000000};
        vecs[5]  = '{32'h40000000, 32'h00000000};
        vecs[6]  = '{32'h00000000, 32'h3FC00000};
        vecs[7]  = '{32'h30000000, 32'h3FC00000};
        vecs[8]  = '{32'h3F400000, 32'h3F400000};
        vecs[9]  = '{32'h3E800000, 32'h3FA00000};
        vecs[10] = '{32'hBF000000, 32'h3F800000};
        vecs[11] = '{32'h7F800000, 32'h00000000};
        vecs[12] = '{32'h00400000, 32'h3FC00000};
        vecs[13] = '{32'h3F800001, 32'h3EFFFFFC};
        vecs[14] = '{32'h33800001, 32'h3FBFFFFF};
        vecs[15] = '{32'h33000000, 32'h3FBFFFFF};
        vecs[16] = '{32'h32800000, 32'h3FC00000};
        vecs[17] = '{32'h3FBFFFFF, 32'h34000000};

        for (int k = 0; k < 3; k++) begin
            mv[k] = 1'b0;
            mr[k] = '0;
            mi[k] = '0;
        end

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h3F000000, 32'h12345678, 32'h0);
        chk("reset_result", Result, 32'h0);
        chk("reset_init", Init_data, 32'h0);

        // Directed table: single pulse, 3-cycle latency, one-cycle Valid
        foreach (vecs[i]) begin
            step(1'b0, 1'b1, 1'b1, vecs[i].num, 32'hA5000000 + 32'(i), vecs[i].exp);
            idle(1'b1);
            idle(1'b1);
            idle(1'b1);
            idle(1'b1);
        end

        // Back-to-back with ce toggling; unsampled slots carry the next operand
        ops[0] = 32'h3F000000;
        ops[1] = 32'h3F800000;
        ops[2] = 32'h3FA00000;
        ops[3] = 32'h3E800000;
        step(1'b0, 1'b1, 1'b1, ops[0], 32'h11110000, ref_sub(ops[0]));
        step(1'b0, 1'b0, 1'b1, ops[1], 32'h11110001, ref_sub(ops[1]));
        step(1'b0, 1'b1, 1'b1, ops[1], 32'h11110001, ref_sub(ops[1]));
        step(1'b0, 1'b1, 1'b1, ops[2], 32'h11110002, ref_sub(ops[2]));
        step(1'b0, 1'b0, 1'b1, ops[3], 32'h11110003, ref_sub(ops[3]));
        step(1'b0, 1'b1, 1'b1, ops[3], 32'h11110003, ref_sub(ops[3]));
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset with two operands in flight
        step(1'b0, 1'b1, 1'b1, 32'h3F000000, 32'hDEAD0001, 32'h3F800000);
        step(1'b0, 1'b1, 1'b1, 32'h3F800000, 32'hDEAD0002, 32'h3F000000);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("flush_result", Result, 32'h0);
        chk("flush_init", Init_data, 32'h0);
        for (int k = 0; k < 5; k++) idle(1'b1);

        // Random stream over [0, 1.5) with random ce and bubbles
        vin  = 0;
        vout = 0;
        for (int k = 0; k < 10000; k++) begin
            c = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 4) != 0);
            e = 8'($urandom_range(0, 127));
            m = $urandom;
            if (e == 8'd127) m[22] = 1'b0;
            n = {m[31], e, m[22:0]};
            step(1'b0, c, v, n, $urandom, ref_sub(n));
            if (c && v) vin++;
            if (c && Valid) vout++;
        end
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            if (Valid) vout++;
        end
        chk("valid_count", 32'(vout), 32'(vin));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/three_halves_sub.md
# three_halves_sub

Newton–Raphson stage of the fast inverse square root datapath: computes `1.5 − h` in IEEE-754 single precision, where `h = 0.5·x·y²` arrives from the upstream multiplier stage. The stage is a 3-deep, `ce`-gated pipeline with a valid bit and a side-band passthrough of the initial-guess word. The following multiplier stage then forms `y·(1.5 − h)`.

## Interface
- `GUARD` – default 2 – extra low-order bits kept during alignment; internal datapath width is `24+GUARD`.
- `clk` in 1 – clock; all state updates on the rising edge.
- `rst` in 1 – reset, synchronous, active-high.
- `ce` in 1 – clock enable; pipeline registers advance only when `ce=1`.
- `Number` in 32 – operand `h`, single-precision float.
- `Init_in` in 32 – side-band word (initial guess `y`); carried alongside `Number`.
- `Valid_in` in 1 – `Number`/`Init_in` qualify this cycle.
- `Result` out 32 – `1.5 − Number`, single precision.
- `Init_data` out 32 – `Init_in` delayed to align with `Result`.
- `Valid` out 1 – `Result`/`Init_data` qualify.

## Operation
- Input decode:
  - `Number[31]` (sign) is ignored; the operand is treated as positive.
  - `E = Number[30:23]`. `E = 0` (zero/denormal) is treated as exact 0.
  - `E = 255` or `E > 127` saturates the result to `+0`.
- S1 – alignment:
  - Compute `d = 127 − E`.
  - `A = 24'hC00000 << GUARD`.
  - `B = ({1, Number[22:0]} << GUARD) >> d`. Bits shifted out are dropped (truncation, no sticky bit).
  - If `d ≥ 24+GUARD`, then `B = 0`.
  - If `B > A`, set the clamp flag.
  - `D = A − B`, width `24+GUARD`, non-negative.
- S2 – leading-zero count:
  - `lz` = number of leading zeros of `D`, range 0..`24+GUARD`.
  - `D = 0` or clamp flag set ⇒ zero flag.
- S3 – normalise and pack:
  - Exponent = `127 − lz`.
  - Mantissa = `(D << lz)[22+GUARD : GUARD]`.
  - Sign = 0.
  - Zero flag ⇒ `Result = 32'h00000000`.
- Rounding: truncation only, matching the multiplier stage.
- `Init_in` and `Valid_in` travel through the same 3 stages unchanged.

## Timing
- Latency is exactly 3 `ce=1` cycles from input sampling to `Result`/`Valid`.
- Throughput is one operand per `ce=1` cycle.
- No backpressure. The `ce=0` behaviour below is the only stall.
- `ce=0`: every stage register holds its value, including the valid bits. Outputs stay stable; inputs are not sampled.
- Bubbles: `Valid_in=0` samples propagate as `Valid=0`. `Result` for such a slot is don't-care; the implementation passes data through unconditionally.
- Reset:
  - Applies on any edge where `rst=1`; it takes priority over `ce`.
  - Clears all stage valid bits, `Valid`, `Result` and `Init_data` to 0.
  - In-flight operands are discarded.
  - On the first `ce=1` edge after `rst` deasserts, `Valid` reflects only newly sampled inputs, 3 `ce` cycles later.
- Boundary results:
  - Exact `1.5` input ⇒ `+0`.
  - Input slightly above `1.5` ⇒ `+0`, never a negative value.
  - Tiny input (`d ≥ 24+GUARD`) ⇒ exactly `32'h3FC00000`.

## Structure
- Shared package `fisr_pkg`:
  - `FP_BIAS = 127`
  - `THREE_HALVES = 32'h3FC00000`
  - `MANT_W = 23`, `EXP_W = 8`
  - A packed float struct `{sign, exp, mant}`, reused by the multiplier stages.
- One sub-module, `lzc_n`: a parameterised, combinational leading-zero counter with width `24+GUARD`, instantiated in S2.
- Everything else lives in the top module: three stage register banks plus the combinational logic between them.

## Test plan
- `Number=32'h3F000000` (0.5), one valid pulse, `ce=1` → after 3 cycles `Result=32'h3F800000`, `Valid=1` for one cycle, `Init_data` equals the `Init_in` sent.
- `Number=32'h3F800000` (1.0) → `32'h3F000000`. `Number=32'h3FA00000` (1.25) → `32'h3E800000`.
- Boundary inputs:
  - `32'h3FC00000` → `32'h00000000`.
  - `32'h3FC00001` → `32'h00000000`.
  - `32'h40000000` (2.0) → `32'h00000000`.
  - `32'h00000000` → `32'h3FC00000`.
  - `32'h30000000` → `32'h3FC00000`.
- Back-to-back 4 operands with `ce` toggling 1,0,1,1,0,1… → results emerge in order, each exactly 3 `ce=1` cycles after its input; outputs frozen while `ce=0`.
- `rst=1` asserted for 1 cycle with 2 operands in flight → next cycle `Valid=0`, `Result=0`, `Init_data=0`; no stale result ever appears afterwards.
- Random positive `Number` in [0, 1.5), 10k samples → `Result` matches a reference model of truncating `1.5 − x` exactly; `Valid` count equals `Valid_in` count.
